muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_div_iter.sv | 44 ++++
 rtl/muldiv_unit.sv | 105 ++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 op encodings and muldiv_unit FSM state encoding
package muldiv_pkg;
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MUL    = 2'd1;
    localparam logic [1:0] ST_DIV    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;
endpackage

// File: rtl/muldiv_div_iter.sv
// muldiv_div_iter: XLEN-step restoring radix-2 unsigned divider
// Ports: clk, rst_n (async active-low); i_start loads i_dividend/i_divisor magnitudes;
// o_quotient/o_remainder show the values produced by the current step; o_done marks the final step.
module muldiv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder,
    output logic            o_done
);
    localparam int CW = $clog2(XLEN + 1);
    logic [XLEN-1:0] r_quo, r_rem, r_dvs;
    logic [CW-1:0]   r_cnt;
    logic [XLEN:0]   w_sh;
    logic            w_ge;
    assign w_sh        = {r_rem, r_quo[XLEN-1]};
    assign w_ge        = w_sh >= {1'b0, r_dvs};
    assign o_remainder = w_ge ? XLEN'(w_sh - {1'b0, r_dvs}) : w_sh[XLEN-1:0];
    assign o_quotient  = {r_quo[XLEN-2:0], w_ge};
    // outputs are next-step values, so the owner can capture them on the last step's edge
    assign o_done      = r_cnt == CW'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
            r_cnt <= CW'(XLEN);
        end else if (r_cnt != '0) begin
            r_quo <= o_quotient;
            r_rem <= o_remainder;
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit, single-cycle multiply and iterative divide
// Ports: clk, rst_n (async active-low); req_* valid/ready request with funct3 op, operands, tag;
// resp_* valid/ready response with result and tag; flush kills in-flight work; busy = not IDLE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_in1,
    input  logic [XLEN-1:0]  req_in2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    input  logic             flush,
    output logic             busy
);
    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a, r_b, r_result;
    logic [TAG_W-1:0]  r_tag;
    logic              w_accept, w_is_div, w_sgn_in, w_rem_in, w_dz, w_ovf, w_special, w_start, w_done;
    logic [XLEN-1:0]   w_special_res, w_mag1, w_mag2, w_quo, w_rem, w_q_fix, w_r_fix, w_div_res, w_mul_res;
    logic              w_sgn_r, w_quo_r, w_a_sx, w_b_sx;
    logic [2*XLEN-1:0] w_a_ext, w_b_ext, w_prod;
    assign req_ready   = r_state == ST_IDLE;
    assign busy        = r_state != ST_IDLE;
    assign resp_valid  = r_state == ST_DONE;
    assign resp_result = r_result;
    assign resp_tag    = r_tag;
    assign w_accept    = req_valid && req_ready && !flush;
    assign w_is_div    = req_op[2];
    assign w_sgn_in    = req_op == OP_DIV || req_op == OP_REM;
    assign w_rem_in    = req_op == OP_REM || req_op == OP_REMU;
    assign w_dz        = req_in2 == '0;
    assign w_ovf       = w_sgn_in && req_in1 == {1'b1, {(XLEN-1){1'b0}}} && req_in2 == '1;
    assign w_special   = w_is_div && (w_dz || w_ovf);
    assign w_special_res = w_dz ? (w_rem_in ? req_in1 : '1) : (w_rem_in ? '0 : req_in1);
    assign w_start     = w_accept && w_is_div && !w_special;
    // the divider works on magnitudes; the most-negative value maps to its unsigned magnitude
    assign w_mag1      = (w_sgn_in && req_in1[XLEN-1]) ? -req_in1 : req_in1;
    assign w_mag2      = (w_sgn_in && req_in2[XLEN-1]) ? -req_in2 : req_in2;
    assign w_sgn_r     = r_op == OP_DIV || r_op == OP_REM;
    assign w_quo_r     = r_op == OP_DIV || r_op == OP_DIVU;
    assign w_q_fix     = (w_sgn_r && (r_a[XLEN-1] ^ r_b[XLEN-1])) ? -w_quo : w_quo;
    assign w_r_fix     = (w_sgn_r && r_a[XLEN-1]) ? -w_rem : w_rem;
    assign w_div_res   = w_quo_r ? w_q_fix : w_r_fix;
    assign w_a_sx      = r_op == OP_MULH || r_op == OP_MULHSU;
    assign w_b_sx      = r_op == OP_MULH;
    assign w_a_ext     = {{XLEN{w_a_sx && r_a[XLEN-1]}}, r_a};
    assign w_b_ext     = {{XLEN{w_b_sx && r_b[XLEN-1]}}, r_b};
    assign w_prod      = w_a_ext * w_b_ext;
    assign w_mul_res   = (r_op == OP_MULH || r_op == OP_MULHSU || r_op == OP_MULHU) ?
                         w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    muldiv_div_iter #(.XLEN(XLEN)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_dividend  (w_mag1),
        .i_divisor   (w_mag2),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_done      (w_done)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_tag    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_op     <= req_op;
                    r_a      <= req_in1;
                    r_b      <= req_in2;
                    r_tag    <= req_tag;
                    r_result <= w_special ? w_special_res : r_result;
                    r_state  <= w_special ? ST_DONE : (w_is_div ? ST_DIV : ST_MUL);
                end
                ST_MUL: begin
                    r_result <= w_mul_res;
                    r_state  <= ST_DONE;
                end
                ST_DIV: if (w_done) begin
                    r_result <= w_div_res;
                    r_state  <= ST_DONE;
                end
                ST_DONE: if (resp_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_ready, resp_valid, resp_ready = 1, flush = 0, busy;
    logic [2:0]  req_op = 0;
    logic [31:0] req_in1 = 0, req_in2 = 0, resp_result;
    logic [4:0]  req_tag = 0, resp_tag;
    logic        s_req_valid = 0, s_req_ready, s_resp_valid, s_busy;
    logic [2:0]  s_req_op = 0;
    logic [15:0] s_in1 = 0, s_in2 = 0, s_result;
    logic [4:0]  s_tag = 0, s_resp_tag;
    int total = 0, bad = 0, cyc = 0, acc_cyc = 0, exp_lat = 0, last_lat = 0;
    logic        exp_valid = 0, seen = 0;
    logic [31:0] exp_res = 0, last_res = 0;
    logic [4:0]  exp_tag = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_in1(req_in1), .req_in2(req_in2), .req_tag(req_tag), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_result(resp_result), .resp_tag(resp_tag), .flush(flush), .busy(busy)
    );
    muldiv_unit #(.XLEN(16), .TAG_W(5)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(s_req_op),
        .req_in1(s_in1), .req_in2(s_in2), .req_tag(s_tag), .resp_valid(s_resp_valid),
        .resp_ready(1'b1), .resp_result(s_result), .resp_tag(s_resp_tag), .flush(1'b0), .busy(s_busy)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa = $signed(a); sb = $signed(b); ua = {32'b0, a}; ub = {32'b0, b};
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin p = sa / sb; return b == 0 ? 32'hFFFF_FFFF : (ovf ? a : p[31:0]); end
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: begin p = sa % sb; return b == 0 ? a : (ovf ? 32'h0 : p[31:0]); end
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int latency(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op < 4) return 2;
        if (b == 0) return 1;
        if ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    always @(negedge clk) if (rst_n) begin
        chk("ready_vs_busy", req_ready, !busy);
        if (req_valid && req_ready && !flush) begin
            acc_cyc = cyc + 1;
            seen = 0;
        end
        if (resp_valid) begin
            if (!exp_valid) chk("unexpected_resp", resp_valid, 0);
            else begin
                chk("result", resp_result, exp_res);
                chk("tag", resp_tag, exp_tag);
                chk("ready_in_done", req_ready, 0);
                if (!seen) begin
                    seen = 1;
                    last_res = resp_result;
                    last_lat = cyc - acc_cyc + 1;
                    chk("latency", last_lat, exp_lat);
                end
                if (resp_ready && !flush) exp_valid = 0;
            end
        end
    end

    task automatic send(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
        int n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("ready_wait", req_ready, 1);
        exp_res = model(op, a, b); exp_tag = tag; exp_lat = latency(op, a, b);
        exp_valid = 1; last_res = 0; last_lat = 0;
        req_valid = 1; req_op = op; req_in1 = a; req_in2 = b; req_tag = tag;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_done(bit rnd);
        int n = 0;
        while (exp_valid && n < 300) begin
            if (rnd) resp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        chk("resp_timeout", exp_valid, 0);
        resp_ready = 1;
    endtask

    task automatic directed(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                            logic [31:0] want, int lat);
        send(op, a, b, 5'(op + 1));
        wait_done(0);
        chk({name, "_value"}, last_res, want);
        chk({name, "_lat"}, last_lat, lat);
    endtask

    initial begin
        logic [2:0] op;
        logic [31:0] a, b;
        int n;
        #23 rst_n = 1;
        @(posedge clk); #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_result", resp_result, 0);
        chk("rst_tag", resp_tag, 0);

        directed("mulhu_ff", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        directed("mulhsu_ff", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        directed("mul_ff", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
        directed("div_m7_2", 4, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33);
        directed("rem_m7_2", 6, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33);
        directed("divu_5_0", 5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        directed("rem_5_0", 6, 32'd5, 32'd0, 32'h0000_0005, 1);
        directed("div_ovf", 4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        directed("rem_ovf", 6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        resp_ready = 0;
        send(0, 32'd6, 32'd7, 5'd9);
        repeat (12) @(posedge clk);
        #1 chk("hold_busy", busy, 1);
        chk("hold_value", last_res, 42);
        resp_ready = 1;
        @(posedge clk); #1;
        chk("idle_on_ready", req_ready, 1);
        chk("hold_drained", exp_valid, 0);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            send(op, a, b, 5'($urandom_range(0, 31)));
            wait_done(1);
        end

        send(4, 32'd100, 32'd7, 5'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1; exp_valid = 0;
        @(posedge clk); #1 flush = 0;
        chk("flush_idle", busy, 0);
        chk("flush_no_valid", resp_valid, 0);
        repeat (40) @(posedge clk);
        #1 directed("mul_after_flush", 0, 32'd3, 32'd4, 32'd12, 2);
        chk("mul_after_flush_tag", resp_tag, 5'd1);

        send(4, 32'd1000, 32'd3, 5'd7);
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        #1 exp_valid = 0;
        chk("arst_valid", resp_valid, 0);
        chk("arst_result", resp_result, 0);
        chk("arst_tag", resp_tag, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("arst_ready", req_ready, 1);
        repeat (40) @(posedge clk);

        #1 s_req_valid = 1; s_req_op = 3'd5; s_in1 = 16'hFFFF; s_in2 = 16'd3; s_tag = 5'd2;
        chk("x16_ready", s_req_ready, 1);
        @(posedge clk); #1 s_req_valid = 0;
        n = 1;
        while (!s_resp_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("x16_divu_lat", n, 17);
        chk("x16_divu_value", s_result, 16'h5555);
        chk("x16_divu_tag", s_resp_tag, 5'd2);
        chk("x16_busy", s_busy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
